pipe_stage_skid: RTL

Parametrised elastic pipeline-stage register that replaces the fixed-field, load-enable inter-stage registers (IF/ID … MEM/WB) with a valid/ready handshake stage. It carries an opaque payload of WIDTH bits (a packed stage bundle), offers full throughput with a registered upstream ready via a one-entry skid buffer, supports synchronous flush for branch/trap squash, and exposes a saturating stall counter for performance monitoring. Instances sit between every pair of pipeline stages in the core.

---
 rtl/pipe_stage_skid_pkg.sv | 34 +++
 rtl/pipe_stage_skid_sat_counter.sv | 38 +++
 rtl/pipe_stage_skid.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid_pkg
//  Description : Shared types for the elastic inter-stage pipeline register.
//                Holds the occupancy-state encoding used by pipe_stage_skid
//                and a helper that maps a state to its number of held
//                payloads.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_stage_skid_pkg;

  // Occupancy encoding, kept as plain constants so legacy code that compares
  // raw 2-bit values keeps working alongside the typed enum below.
  localparam logic [1:0] C_ST_EMPTY = 2'b00;
  localparam logic [1:0] C_ST_FULL  = 2'b01;
  localparam logic [1:0] C_ST_SKID  = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = C_ST_EMPTY,  // nothing held
    ST_FULL  = C_ST_FULL,   // main entry valid
    ST_SKID  = C_ST_SKID    // main and skid entries valid
  } pipe_state_t;

  // Number of payloads held in a given state.
  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    case (s)
      ST_FULL:  state_occupancy = 2'd1;
      ST_SKID:  state_occupancy = 2'd2;
      default:  state_occupancy = 2'd0;
    endcase
  endfunction

endpackage : pipe_stage_skid_pkg
`default_nettype wire

// File: rtl/pipe_stage_skid_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter for performance monitoring. Counts
//                cycles with i_inc high, sticks at all-ones, and is cleared
//                only by the synchronous reset.
//  Ports       : clk      - clock
//                rst      - synchronous active-high clear
//                i_inc    - increment request
//                o_count  - current count (CNT_W bits)
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Elastic valid/ready pipeline-stage register carrying an
//                opaque WIDTH-bit stage bundle. With SKID_EN=1 a second
//                (skid) entry lets in_ready come straight from the state
//                register while still sustaining one payload per cycle.
//                With SKID_EN=0 the stage is a single entry whose in_ready
//                follows out_ready combinationally. Supports synchronous
//                flush (branch/trap squash) and a saturating stall counter.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                flush             - drop held entries and same-cycle input
//                in_valid/in_ready/in_data    - upstream handshake + payload
//                out_valid/out_ready/out_data - downstream handshake + payload
//                stall_cnt         - cycles with out_valid & !out_ready
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t      r_state;
  pipe_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_skid_data;

  logic w_ready_raw;
  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_stall_inc;

  // --------------------------------------------------------------------------
  // Upstream ready
  // --------------------------------------------------------------------------
  generate
    if (SKID_EN) begin : g_ready_skid
      // Decoded from the state register only: the skid entry absorbs the one
      // payload that arrives while the downstream stall is being noticed.
      assign w_ready_raw = (r_state != ST_SKID);
    end else begin : g_ready_flow
      // Single entry: can only take a new payload if it is empty or the held
      // payload leaves in the same cycle.
      assign w_ready_raw = (r_state == ST_EMPTY) | out_ready;
    end
  endgenerate

  // Nothing is accepted while reset is held.
  assign in_ready   = w_ready_raw & ~rst;
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Next-state and load decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_FULL;
          w_load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_in_fire && SKID_EN) begin
          // Downstream stalled: park the newcomer behind the main entry.
          w_state_nxt = ST_SKID;
          w_load_skid = 1'b1;
        end
      end
      ST_SKID: begin
        if (w_out_fire) begin
          w_state_nxt      = ST_FULL;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    // Squash wins over every handshake; data registers are simply left as-is.
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State and main entry
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
    end else if (w_load_main_in) begin
      r_main <= in_data;
    end else if (w_load_main_skid) begin
      r_main <= w_skid_data;
    end
  end

  // --------------------------------------------------------------------------
  // Skid entry
  // --------------------------------------------------------------------------
  generate
    if (SKID_EN) begin : g_skid
      logic [WIDTH-1:0] r_skid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_skid <= '0;
        end else if (w_load_skid) begin
          r_skid <= in_data;
        end
      end

      assign w_skid_data = r_skid;
    end else begin : g_no_skid
      assign w_skid_data = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stall counter: a flushed cycle is not a stall, the payload is discarded.
  // --------------------------------------------------------------------------
  assign w_stall_inc = out_valid & ~out_ready & ~flush;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

endmodule : pipe_stage_skid
`default_nettype wire
